// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one shared N-bit ripple-carry adder, round-robin
// arbitration across NREQ requesters, registered result on a valid/ready port.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   req[NREQ]         per-requester operation pending
//   a_flat, b_flat    packed operands, requester i at [i*N +: N]
//   cin[NREQ]         explicit carry-in (used when chain[i]=0)
//   chain[NREQ]       use requester's saved carry-out as carry-in
//   gnt[NREQ]         one-hot combinational grant (op accepted this edge)
//   rsp_valid/ready   result handshake
//   rsp_id            requester owning the result
//   rsp_sum, rsp_cout registered sum and carry-out
module adder_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_flat,
    input  logic [NREQ*N-1:0] b_flat,
    input  logic [NREQ-1:0]   cin,
    input  logic [NREQ-1:0]   chain,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ-1);

    logic [0:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] carry_q;

    logic            can_accept;
    logic            any_gnt;
    logic [IDW-1:0]  gidx;

    logic [N-1:0]    a_sel;
    logic [N-1:0]    b_sel;
    logic            c_sel;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) | rsp_ready;

    // Round-robin search starting at rr_ptr; first pending requester wins.
    always_comb begin
        logic [IDW:0] idx;
        gnt     = '0;
        gidx    = '0;
        any_gnt = 1'b0;
        idx     = '0;
        if (can_accept && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, rr_ptr} + (IDW+1)'(k);
                if (idx >= NREQ_W)
                    idx = idx - NREQ_W;
                if (!any_gnt && req[idx[IDW-1:0]]) begin
                    any_gnt = 1'b1;
                    gidx    = idx[IDW-1:0];
                end
            end
        end
        if (any_gnt)
            gnt[gidx] = 1'b1;
    end

    // Operand mux feeding the single shared adder.
    always_comb begin
        a_sel = a_flat[int'(gidx)*N +: N];
        b_sel = b_flat[int'(gidx)*N +: N];
        c_sel = chain[gidx] ? carry_q[gidx] : cin[gidx];
    end

    // Ripple-carry adder, bit-serial carry propagation.
    always_comb begin
        logic c;
        logic p;
        c       = c_sel;
        add_sum = '0;
        for (int k = 0; k < N; k++) begin
            p          = a_sel[k] ^ b_sel[k];
            add_sum[k] = p ^ c;
            c          = (a_sel[k] & b_sel[k]) | (c & p);
        end
        add_cout = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            rr_ptr   <= '0;
            carry_q  <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else if (any_gnt) begin
            // A grant while FULL implies rsp_ready: pop and refill together.
            state          <= FULL;
            rsp_sum        <= add_sum;
            rsp_cout       <= add_cout;
            rsp_id         <= gidx;
            carry_q[gidx]  <= add_cout;
            rr_ptr         <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end else if (state == FULL && rsp_ready) begin
            state <= EMPTY;
        end
    end

endmodule
